// File: rtl/rgmii_rx_frame_checker.sv
// RGMII receive frame checker: strips preamble/SFD, checks CRC-32 and length,
// drops the FCS via a 4-byte delay line and keeps saturating frame statistics.
module rgmii_rx_frame_checker #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
) (
  input  logic             clk125,
  input  logic             s_aresetn,
  input  logic [7:0]       rx_data,
  input  logic             rx_val,
  input  logic             rx_err,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic             cnt_clr,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic             m_good,
  output logic             m_crc_err,
  output logic             m_len_err,
  output logic             m_phy_err,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_len_err,
  output logic [CNT_W-1:0] cnt_pre_err
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, DONE, DROP} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

  state_t          state, state_n;
  logic [3:0]      pre_cnt, pre_cnt_n, pre_base;
  logic [31:0]     crc;
  logic [15:0]     len;
  logic            phy_flag, sent;
  logic [3:0][7:0] dl;
  logic [2:0]      fill;
  logic            sof_v, pre_go, start_data, take, fin, trunc, pre_err_inc;
  logic            emit, crc_bad, len_bad, fin_phy, fin_out;
  logic            runt_q, pre_err_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign sof_v = rx_sof & rx_val;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n     = state;
    pre_cnt_n   = pre_cnt;
    pre_base    = 4'd0;
    pre_go      = 1'b0;
    start_data  = 1'b0;
    take        = 1'b0;
    fin         = 1'b0;
    trunc       = 1'b0;
    pre_err_inc = 1'b0;
    case (state)
      IDLE: pre_go = sof_v;
      DONE: begin
        fin     = 1'b1;
        state_n = IDLE;
        pre_go  = sof_v;
      end
      PRE: begin
        if (sof_v) pre_go = 1'b1;
        else if (rx_val) begin
          pre_go   = 1'b1;
          pre_base = pre_cnt;
        end else if (rx_eof) begin
          state_n     = IDLE;
          pre_err_inc = 1'b1;
        end
      end
      DATA: begin
        // A new SOF closes the current frame and starts the next one in the same cycle.
        if (sof_v) begin
          fin    = 1'b1;
          trunc  = 1'b1;
          pre_go = 1'b1;
        end else begin
          take = rx_val;
          if (rx_eof) state_n = DONE;
        end
      end
      DROP: begin
        if (sof_v) pre_go = 1'b1;
        else if (rx_eof) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (pre_go) begin
      pre_cnt_n = 4'd0;
      if (rx_err || (pre_base > 4'd7) || ((rx_data != 8'h55) && (rx_data != 8'hD5))) begin
        state_n     = DROP;
        pre_err_inc = 1'b1;
      end else if (rx_data == 8'hD5) begin
        state_n    = DATA;
        start_data = 1'b1;
      end else begin
        state_n   = PRE;
        pre_cnt_n = pre_base + 4'd1;
      end
      if (rx_eof) begin
        if (state_n == DATA) state_n = DONE;
        else begin
          if (state_n == PRE) pre_err_inc = 1'b1;
          state_n = IDLE;
        end
      end
    end
  end

  assign emit    = take && (fill == 3'd4);
  assign crc_bad = (crc != CRC_RESIDUE);
  assign len_bad = (len < MIN_L) || (len > MAX_L);
  assign fin_phy = phy_flag | trunc;
  assign fin_out = fin & sent;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk125) begin
    if (!s_aresetn) begin
      state     <= IDLE;
      pre_cnt   <= 4'd0;
      crc       <= 32'h0;
      len       <= 16'h0;
      phy_flag  <= 1'b0;
      sent      <= 1'b0;
      // NOTE: the delay line is small enough to clear on reset, so no stale FCS survives.
      dl        <= '0;
      fill      <= 3'd0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      m_good    <= 1'b0;
      m_crc_err <= 1'b0;
      m_len_err <= 1'b0;
      m_phy_err <= 1'b0;
      runt_q    <= 1'b0;
      pre_err_q <= 1'b0;
    end else begin
      state   <= state_n;
      pre_cnt <= pre_cnt_n;
      if (start_data) begin
        crc      <= 32'hFFFF_FFFF;
        len      <= 16'h0;
        phy_flag <= 1'b0;
        sent     <= 1'b0;
        fill     <= 3'd0;
      end else if (take) begin
        crc      <= crc_byte(crc, rx_data);
        phy_flag <= phy_flag | rx_err;
        dl       <= {dl[2:0], rx_data};
        if (len != 16'hFFFF) len <= len + 16'd1;
        if (fill != 3'd4) fill <= fill + 3'd1;
        if (emit) sent <= 1'b1;
      end
      m_valid   <= emit;
      m_sof     <= emit & ~sent;
      m_data    <= emit ? dl[3] : 8'h00;
      m_eof     <= fin_out;
      m_good    <= fin_out & ~(crc_bad | len_bad | fin_phy);
      m_crc_err <= fin_out & crc_bad;
      m_len_err <= fin_out & len_bad;
      m_phy_err <= fin_out & fin_phy;
      runt_q    <= fin & ~sent;
      pre_err_q <= pre_err_inc;
    end
  end

  always_ff @(posedge clk125) begin
    if (!s_aresetn || cnt_clr) begin
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_len_err <= '0;
      cnt_pre_err <= '0;
    end else begin
      cnt_good    <= sat_inc(cnt_good, m_eof & m_good);
      cnt_crc_err <= sat_inc(cnt_crc_err, m_eof & m_crc_err);
      cnt_len_err <= sat_inc(cnt_len_err, (m_eof & m_len_err) | runt_q);
      cnt_pre_err <= sat_inc(cnt_pre_err, pre_err_q);
    end
  end

endmodule
